// File: rtl/secuenciador_brazo.sv
// secuenciador_brazo: plays back servo target words from memoriaROM, holding each for T ticks.
// Optional feature macro SEQ_LOOP_EN adds a LOOP input that restarts the table at END.
module secuenciador_brazo #(
  parameter int         CLK_HZ    = 50_000_000,
  parameter int         TICK_MS   = 20,
  parameter logic [7:0] FIRST_POS = 8'd0,
  parameter logic [7:0] LAST_POS  = 8'd11
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        STOP,
`ifdef SEQ_LOOP_EN
  input  logic        LOOP,
`endif
  input  logic [31:0] DATOS,
  output logic [7:0]  POS,
  output logic [7:0]  SERVO1,
  output logic [7:0]  SERVO2,
  output logic [7:0]  SERVO3,
  output logic        BUSY,
  output logic        STEP,
  output logic        DONE
);

  localparam int CYC_TICK = CLK_HZ / 1000 * TICK_MS;
  localparam int PW       = (CYC_TICK > 1) ? $clog2(CYC_TICK) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CYC_TICK - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_HOLD,
    S_END
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    pos_q, pos_d;
  logic [7:0]    servo1_q, servo1_d;
  logic [7:0]    servo2_q, servo2_d;
  logic [7:0]    servo3_q, servo3_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          busy_q, busy_d;
  logic          step_q, step_d;
  logic          done_q, done_d;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    servo1_d = servo1_q;
    servo2_d = servo2_q;
    servo3_d = servo3_q;
    tcnt_d   = tcnt_q;
    presc_d  = presc_q;
    step_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          pos_d   = FIRST_POS;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_LOAD;
      S_LOAD: begin
        if (DATOS[7:0] == 8'd0) begin
          done_d  = 1'b1;
          state_d = S_END;
        end else begin
          servo1_d = DATOS[31:24];
          servo2_d = DATOS[23:16];
          servo3_d = DATOS[15:8];
          tcnt_d   = DATOS[7:0];
          presc_d  = '0;
          step_d   = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        // The final tick wrap leaves HOLD directly, so HOLD lasts exactly T*CYC_TICK cycles.
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          tcnt_d  = tcnt_q - 8'd1;
          if (tcnt_q == 8'd1) begin
            if (pos_q == LAST_POS) begin
              done_d  = 1'b1;
              state_d = S_END;
            end else begin
              pos_d   = pos_q + 8'd1;
              state_d = S_FETCH;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_END: begin
`ifdef SEQ_LOOP_EN
        if (LOOP) begin
          pos_d   = FIRST_POS;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a START seen in the same cycle.
    if (STOP) begin
      state_d  = S_IDLE;
      pos_d    = pos_q;
      servo1_d = servo1_q;
      servo2_d = servo2_q;
      servo3_d = servo3_q;
      tcnt_d   = tcnt_q;
      presc_d  = presc_q;
      step_d   = 1'b0;
      done_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      pos_q    <= FIRST_POS;
      servo1_q <= 8'd0;
      servo2_q <= 8'd0;
      servo3_q <= 8'd0;
      tcnt_q   <= 8'd0;
      presc_q  <= '0;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      servo1_q <= servo1_d;
      servo2_q <= servo2_d;
      servo3_q <= servo3_d;
      tcnt_q   <= tcnt_d;
      presc_q  <= presc_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  assign POS    = pos_q;
  assign SERVO1 = servo1_q;
  assign SERVO2 = servo2_q;
  assign SERVO3 = servo3_q;
  assign BUSY   = busy_q;
  assign STEP   = step_q;
  assign DONE   = done_q;

endmodule
